// File: rtl/room_occupancy_ctrl.sv
// Room occupancy and door controller: turns entry/exit sensor levels into single events,
// tracks occupancy up to CAPACITY and holds the door open for DOOR_HOLD cycles per accepted event.
module room_occupancy_ctrl #(
  parameter int CAPACITY  = 10,
  parameter int DOOR_HOLD = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ent_i,
  input  logic             exit_i,
  output logic             in_o,
  output logic             out_o,
  output logic             reject_o,
  output logic             open_o,
  output logic             close_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int TW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TW-1:0]    HOLD_LOAD = TW'(DOOR_HOLD - 1);
  localparam logic [TW-1:0]    TMR_ONE   = TW'(1);

  typedef enum logic {CLOSED, OPEN} doorState_e;

  doorState_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ent_q, exit_q;
  logic             in_q, in_d;
  logic             out_q, out_d;
  logic             reject_q, reject_d;

  logic entEv, exitEv, entAcc, exitAcc, anyAcc;

  assign entEv   = ent_i & ~ent_q;
  assign exitEv  = exit_i & ~exit_q;
  // A simultaneous exit frees the slot, so a full room can still admit the entrant.
  assign exitAcc = exitEv & (count_q != '0);
  assign entAcc  = entEv & ((count_q != CAP) | exitAcc);
  assign anyAcc  = entAcc | exitAcc;

  always_comb begin
    count_d  = count_q;
    in_d     = entAcc;
    out_d    = exitAcc;
    reject_d = entEv & ~entAcc;
    if (entAcc && !exitAcc) begin
      count_d = count_q + CNT_ONE;
    end else if (exitAcc && !entAcc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      CLOSED: begin
        if (anyAcc) begin
          state_d = OPEN;
          timer_d = HOLD_LOAD;
        end
      end
      OPEN: begin
        if (anyAcc) begin
          timer_d = HOLD_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TMR_ONE;
        end else begin
          state_d = CLOSED;
        end
      end
      default: begin
        state_d = CLOSED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CLOSED;
      timer_q  <= '0;
      count_q  <= '0;
      ent_q    <= 1'b0;
      exit_q   <= 1'b0;
      in_q     <= 1'b0;
      out_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      ent_q    <= ent_i;
      exit_q   <= exit_i;
      in_q     <= in_d;
      out_q    <= out_d;
      reject_q <= reject_d;
    end
  end

  assign in_o     = in_q;
  assign out_o    = out_q;
  assign reject_o = reject_q;
  assign open_o   = (state_q == OPEN);
  assign close_o  = ~open_o;
  assign count_o  = count_q;
  assign full_o   = (count_q == CAP);
  assign empty_o  = (count_q == '0);

endmodule
